// File: rtl/alu_instr_sequencer_pkg.sv
// Shared definitions for the MiniAlu fetch/issue sequencer: opcodes, field positions,
// sequencer states and the opcode classifier used by the issue logic.
package alu_instr_sequencer_pkg;

  localparam int FIELD_OP_W    = 4;
  localparam int FIELD_DST_LSB = 16;

  localparam logic [FIELD_OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [FIELD_OP_W-1:0] OP_LED = 4'h1;
  localparam logic [FIELD_OP_W-1:0] OP_BLE = 4'h2;
  localparam logic [FIELD_OP_W-1:0] OP_STO = 4'h3;
  localparam logic [FIELD_OP_W-1:0] OP_ADD = 4'h4;
  localparam logic [FIELD_OP_W-1:0] OP_JMP = 4'h5;
  localparam logic [FIELD_OP_W-1:0] OP_SUB = 4'h6;
  localparam logic [FIELD_OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } seqState_e;

  typedef enum logic [1:0] {
    CLS_SEQ,
    CLS_JMP,
    CLS_BLE,
    CLS_HLT
  } opClass_e;

  // Anything the sequencer does not redirect on (including unknown opcodes) flows sequentially.
  function automatic opClass_e classifyOp(input logic [FIELD_OP_W-1:0] op);
    opClass_e cls;
    cls = CLS_SEQ;
    case (op)
      OP_JMP:                                   cls = CLS_JMP;
      OP_BLE:                                   cls = CLS_BLE;
      OP_HLT:                                   cls = CLS_HLT;
      OP_NOP, OP_LED, OP_STO, OP_ADD, OP_SUB:   cls = CLS_SEQ;
      default:                                  cls = CLS_SEQ;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_seq_pc.sv
// Program counter for the sequencer: clear beats load beats increment, otherwise hold.
// Increment wraps modulo 2^ADDR_W with no flag.
module alu_seq_pc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] loadVal_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clear_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = loadVal_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/issue controller for the MiniAlu datapath: drives the registered program ROM,
// issues one instruction per cycle, resolves JMP/BLE with a single flush bubble, handles HLT/stall.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int OP_W    = 4,
  parameter int INSTR_W = 28,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               stall_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               branchTaken_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               issue_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   retired_o
);

  seqState_e        state_q;
  seqState_e        state_d;
  logic             pcClear;
  logic             pcLoad;
  logic             pcInc;
  logic             issue;
  logic             halted;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic [OP_W-1:0]  op;
  opClass_e         opClass;

  assign op      = instr_i[INSTR_W-1 -: OP_W];
  assign opClass = classifyOp(op);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run_i) state_d = ST_PRIME;
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall_i) begin
          case (opClass)
            CLS_JMP: state_d = ST_FLUSH;
            CLS_BLE: if (branchTaken_i) state_d = ST_FLUSH;
            CLS_HLT: state_d = ST_HALT;
            default: state_d = ST_RUN;
          endcase
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT:  if (run_i) state_d = ST_PRIME;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The word arriving during FLUSH was fetched from the fall-through address, so it is never issued.
  always_comb begin
    pcClear = 1'b0;
    pcLoad  = 1'b0;
    pcInc   = 1'b0;
    issue   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_IDLE:  pcClear = 1'b1;
      ST_PRIME: pcInc = 1'b1;
      ST_RUN: begin
        if (!stall_i) begin
          issue = 1'b1;
          case (opClass)
            CLS_JMP: pcLoad = 1'b1;
            CLS_BLE: begin
              pcLoad = branchTaken_i;
              pcInc  = !branchTaken_i;
            end
            CLS_HLT: pcInc = 1'b0;
            default: pcInc = 1'b1;
          endcase
        end
      end
      ST_FLUSH: pcInc = 1'b1;
      ST_HALT: begin
        halted  = 1'b1;
        pcClear = run_i;
      end
      default: pcClear = 1'b1;
    endcase
  end

  alu_seq_pc #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (pcClear),
    .load_i   (pcLoad),
    .loadVal_i(instr_i[FIELD_DST_LSB +: ADDR_W]),
    .inc_i    (pcInc),
    .pc_o     (pc_o)
  );

  always_comb begin
    retired_d = retired_q;
    if (issue && (retired_q != '1)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign issue_o   = issue;
  assign instr_o   = issue ? instr_i : '0;
  assign halted_o  = halted;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: a registered ROM model feeds each DUT; a narrow
// second instance (4-bit PC, 4-bit counter) covers PC wrap and counter saturation.
module tb_alu_instr_sequencer;

  localparam logic [27:0] I_ADD = 28'h4010203;
  localparam logic [27:0] I_SUB = 28'h6040506;
  localparam logic [27:0] I_HLT = 28'hF000000;
  localparam logic [27:0] I_JMP = 28'h5100000;
  localparam logic [27:0] I_BLE = 28'h2200708;
  localparam logic [27:0] N1    = 28'h0000011;
  localparam logic [27:0] N2    = 28'h0000022;
  localparam logic [27:0] N3    = 28'h0000033;
  localparam logic [27:0] N4    = 28'h0000044;

  // ctl = {rst, run, stall, taken}; flg = {issue, halted}
  typedef struct {
    logic [3:0]  ctl;
    logic [7:0]  pc;
    logic [1:0]  flg;
    logic [27:0] instr;
    logic [15:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic stall = 1'b0;
  logic taken = 1'b0;
  logic runB = 1'b0;

  logic [27:0] romA [256];
  logic [27:0] romB [16];
  logic [27:0] romQA = 28'h0;
  logic [27:0] romQB = 28'h0;

  logic [7:0]  pcA;
  logic        issueA;
  logic [27:0] instrA;
  logic        haltedA;
  logic [15:0] retiredA;
  logic [3:0]  pcB;
  logic        issueB;
  logic [27:0] instrB;
  logic        haltedB;
  logic [3:0]  retiredB;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // ROM holds its output while the datapath stalls so the same word is re-presented.
  always @(posedge clk) if (!stall) romQA <= romA[pcA];
  always @(posedge clk) romQB <= romB[pcB];

  alu_instr_sequencer dutA (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .stall_i      (stall),
    .instr_i      (romQA),
    .branchTaken_i(taken),
    .pc_o         (pcA),
    .issue_o      (issueA),
    .instr_o      (instrA),
    .halted_o     (haltedA),
    .retired_o    (retiredA)
  );

  alu_instr_sequencer #(
    .ADDR_W(4),
    .CNT_W (4)
  ) dutB (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (runB),
    .stall_i      (1'b0),
    .instr_i      (romQB),
    .branchTaken_i(1'b0),
    .pc_o         (pcB),
    .issue_o      (issueB),
    .instr_o      (instrB),
    .halted_o     (haltedB),
    .retired_o    (retiredB)
  );

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] ctl);
    @(posedge clk);
    #1;
    {rst, run, stall, taken} = ctl;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] ePc, input logic [1:0] eFlg,
                             input logic [27:0] eInstr, input logic [15:0] eRet);
    checkField({tag, " pc"},      32'(pcA),      32'(ePc));
    checkField({tag, " issue"},   32'(issueA),   32'(eFlg[1]));
    checkField({tag, " instr"},   32'(instrA),   32'(eInstr));
    checkField({tag, " halted"},  32'(haltedA),  32'(eFlg[0]));
    checkField({tag, " retired"}, 32'(retiredA), 32'(eRet));
  endtask

  task automatic cyc(input string tag, input logic [3:0] ctl, input logic [7:0] ePc,
                     input logic [1:0] eFlg, input logic [27:0] eInstr, input logic [15:0] eRet);
    applyStimulus(ctl);
    checkOutput(tag, ePc, eFlg, eInstr, eRet);
  endtask

  task automatic clearRomA();
    for (int i = 0; i < 256; i++) romA[i] = 28'h0;
  endtask

  task automatic loadBranchRom();
    clearRomA();
    romA[0] = N1; romA[1] = N2; romA[2] = N3; romA[3] = N4;
    romA[4] = I_BLE; romA[5] = I_ADD; romA[6] = I_HLT;
    romA[8'h20] = I_SUB; romA[8'h21] = I_HLT;
  endtask

  vec_t basicVec [7];

  initial begin
    basicVec[0] = '{4'b0100, 8'h00, 2'b00, 28'h0,  16'd0};
    basicVec[1] = '{4'b0000, 8'h00, 2'b00, 28'h0,  16'd0};
    basicVec[2] = '{4'b0000, 8'h01, 2'b10, I_ADD,  16'd0};
    basicVec[3] = '{4'b0100, 8'h02, 2'b10, I_SUB,  16'd1};
    basicVec[4] = '{4'b0000, 8'h03, 2'b10, I_HLT,  16'd2};
    basicVec[5] = '{4'b0000, 8'h03, 2'b01, 28'h0,  16'd3};
    basicVec[6] = '{4'b0000, 8'h03, 2'b01, 28'h0,  16'd3};
    for (int i = 0; i < 16; i++) romB[i] = 28'h0000100 + 28'(i);

    // Straight-line program ending in HLT
    clearRomA();
    romA[0] = I_ADD; romA[1] = I_SUB; romA[2] = I_HLT;
    applyStimulus(4'b1000);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(basicVec[i].ctl);
      checkOutput($sformatf("basic[%0d]", i), basicVec[i].pc, basicVec[i].flg,
                  basicVec[i].instr, basicVec[i].ret);
    end

    // Taken JMP: one bubble, fall-through word never issued
    clearRomA();
    romA[0] = I_JMP; romA[1] = I_ADD; romA[8'h10] = I_HLT; romA[8'h11] = I_SUB;
    applyStimulus(4'b1000);
    cyc("jmp idle",   4'b0100, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("jmp prime",  4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("jmp issue",  4'b0000, 8'h01, 2'b10, I_JMP, 16'd0);
    cyc("jmp flush",  4'b0000, 8'h10, 2'b00, 28'h0, 16'd1);
    cyc("jmp target", 4'b0000, 8'h11, 2'b10, I_HLT, 16'd1);
    cyc("jmp halted", 4'b0000, 8'h11, 2'b01, 28'h0, 16'd2);

    // BLE not taken, then restart from HALT with BLE taken
    loadBranchRom();
    applyStimulus(4'b1000);
    cyc("ble idle",    4'b0100, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("ble prime",   4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("ble n1",      4'b0000, 8'h01, 2'b10, N1,    16'd0);
    cyc("ble n2",      4'b0000, 8'h02, 2'b10, N2,    16'd1);
    cyc("ble n3",      4'b0000, 8'h03, 2'b10, N3,    16'd2);
    cyc("ble n4",      4'b0000, 8'h04, 2'b10, N4,    16'd3);
    cyc("ble nt",      4'b0000, 8'h05, 2'b10, I_BLE, 16'd4);
    cyc("ble fall",    4'b0001, 8'h06, 2'b10, I_ADD, 16'd5);
    cyc("ble hlt",     4'b0000, 8'h07, 2'b10, I_HLT, 16'd6);
    cyc("ble restart", 4'b0100, 8'h07, 2'b01, 28'h0, 16'd7);
    cyc("ble prime2",  4'b0000, 8'h00, 2'b00, 28'h0, 16'd7);
    cyc("ble2 n1",     4'b0000, 8'h01, 2'b10, N1,    16'd7);
    cyc("ble2 n2",     4'b0000, 8'h02, 2'b10, N2,    16'd8);
    cyc("ble2 n3",     4'b0000, 8'h03, 2'b10, N3,    16'd9);
    cyc("ble2 n4",     4'b0000, 8'h04, 2'b10, N4,    16'd10);
    cyc("ble taken",   4'b0001, 8'h05, 2'b10, I_BLE, 16'd11);
    cyc("ble flush",   4'b0000, 8'h20, 2'b00, 28'h0, 16'd12);
    cyc("ble target",  4'b0000, 8'h21, 2'b10, I_SUB, 16'd12);
    cyc("ble hlt2",    4'b0000, 8'h22, 2'b10, I_HLT, 16'd13);
    cyc("ble halted2", 4'b0000, 8'h22, 2'b01, 28'h0, 16'd14);

    // Three-cycle stall: PC frozen, nothing issued, then the same stream resumes
    applyStimulus(4'b1000);
    cyc("stl idle",  4'b0100, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("stl prime", 4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("stl n1",    4'b0000, 8'h01, 2'b10, N1,    16'd0);
    cyc("stl n2",    4'b0000, 8'h02, 2'b10, N2,    16'd1);
    cyc("stl s1",    4'b0010, 8'h03, 2'b00, 28'h0, 16'd2);
    cyc("stl s2",    4'b0011, 8'h03, 2'b00, 28'h0, 16'd2);
    cyc("stl s3",    4'b0010, 8'h03, 2'b00, 28'h0, 16'd2);
    cyc("stl n3",    4'b0000, 8'h03, 2'b10, N3,    16'd2);
    cyc("stl n4",    4'b0000, 8'h04, 2'b10, N4,    16'd3);
    cyc("stl ble",   4'b0000, 8'h05, 2'b10, I_BLE, 16'd4);
    cyc("stl add",   4'b0000, 8'h06, 2'b10, I_ADD, 16'd5);
    cyc("stl hlt",   4'b0000, 8'h07, 2'b10, I_HLT, 16'd6);
    cyc("stl halt",  4'b0000, 8'h07, 2'b01, 28'h0, 16'd7);

    // Reset during FLUSH, then reset together with iRun while halted
    applyStimulus(4'b1000);
    cyc("rf idle",   4'b0100, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("rf prime",  4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("rf n1",     4'b0000, 8'h01, 2'b10, N1,    16'd0);
    cyc("rf n2",     4'b0000, 8'h02, 2'b10, N2,    16'd1);
    cyc("rf n3",     4'b0000, 8'h03, 2'b10, N3,    16'd2);
    cyc("rf n4",     4'b0000, 8'h04, 2'b10, N4,    16'd3);
    cyc("rf ble",    4'b0001, 8'h05, 2'b10, I_BLE, 16'd4);
    cyc("rf flush",  4'b1000, 8'h20, 2'b00, 28'h0, 16'd5);
    cyc("rf reset",  4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("rf idle2",  4'b0100, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("rh prime",  4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("rh n1",     4'b0000, 8'h01, 2'b10, N1,    16'd0);
    cyc("rh n2",     4'b0000, 8'h02, 2'b10, N2,    16'd1);
    cyc("rh n3",     4'b0000, 8'h03, 2'b10, N3,    16'd2);
    cyc("rh n4",     4'b0000, 8'h04, 2'b10, N4,    16'd3);
    cyc("rh ble",    4'b0000, 8'h05, 2'b10, I_BLE, 16'd4);
    cyc("rh add",    4'b0000, 8'h06, 2'b10, I_ADD, 16'd5);
    cyc("rh hlt",    4'b0000, 8'h07, 2'b10, I_HLT, 16'd6);
    cyc("rh halted", 4'b1100, 8'h07, 2'b01, 28'h0, 16'd7);
    cyc("rh reset",  4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);
    cyc("rh stay",   4'b0000, 8'h00, 2'b00, 28'h0, 16'd0);

    // Narrow instance: PC wraps F->0 and the 4-bit retired counter saturates at 15
    applyStimulus(4'b1000);
    for (int k = 0; k < 24; k++) begin
      logic [3:0]  ePc;
      logic        eIss;
      logic [27:0] eInstr;
      logic [3:0]  eRet;
      @(posedge clk);
      #1;
      {rst, run, stall, taken} = 4'b0000;
      runB = (k == 0);
      @(negedge clk);
      if (k < 2) begin
        ePc = 4'h0; eIss = 1'b0; eInstr = 28'h0; eRet = 4'h0;
      end else begin
        ePc    = 4'((k - 1) % 16);
        eIss   = 1'b1;
        eInstr = romB[(k - 2) % 16];
        eRet   = (k - 2 > 15) ? 4'hF : 4'(k - 2);
      end
      checkField($sformatf("wrap[%0d] pc", k),      32'(pcB),      32'(ePc));
      checkField($sformatf("wrap[%0d] issue", k),   32'(issueB),   32'(eIss));
      checkField($sformatf("wrap[%0d] instr", k),   32'(instrB),   32'(eInstr));
      checkField($sformatf("wrap[%0d] retired", k), 32'(retiredB), 32'(eRet));
    end
    checkField("wrap halted", 32'(haltedB), 32'(1'b0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
